// File: rtl/gm_pkg.sv
// Shared types and helpers for the global-memory responder.
package gm_pkg;

  // Responder FSM: sample in IDLE, then count down the latency of the served channel.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } gm_state_e;

  // Ceiling log2; CLogB2(1) == 0. Used to size word indices and counters.
  function automatic int CLogB2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Geometry of the default configuration (32-bit words, 1024 words).
  localparam int BYTES          = 32 / 8;
  localparam int WORD_IDX_LSB   = CLogB2(BYTES);
  localparam int WORD_IDX_WIDTH = CLogB2(1024);

endpackage

// File: rtl/gm_sram_be.sv
// Single-port byte-enabled SRAM with a registered read port.
// Each byte lane is its own array so the tools can map it onto block RAM
// with per-lane write enables; the array itself is never reset.
module gm_sram_be #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                 iClk,
  input  logic                 iEn,
  input  logic                 iWe,
  input  logic [WIDTH/8-1:0]   iByteEn,
  input  logic [ADDR_W-1:0]    iAddr,
  input  logic [WIDTH-1:0]     iWData,
  output logic [WIDTH-1:0]     oRData
);

  localparam int LANES = WIDTH / 8;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : gLane
      logic [7:0] laneMem [DEPTH];
      logic [7:0] rLaneData;

      // Write the enabled byte, or capture the addressed byte on a read access.
      // The read register holds its value until the next read access.
      always_ff @(posedge iClk) begin
        if (iEn) begin
          if (iWe) begin
            if (iByteEn[gi]) begin
              laneMem[iAddr] <= iWData[gi*8 +: 8];
            end
          end else begin
            rLaneData <= laneMem[iAddr];
          end
        end
      end

      assign oRData[gi*8 +: 8] = rLaneData;
    end
  endgenerate

endmodule

// File: rtl/gm_responder.sv
// Memory-side endpoint of the GM interface: serialises the arbiter's read
// and write channels onto one byte-enabled SRAM and answers each with a
// single-cycle pulse after a programmable latency.
module gm_responder
  import gm_pkg::*;
#(
  parameter int D_WIDTH              = 32,
  parameter int INTERFACE_ADDR_WIDTH = 32,
  parameter int INTERFACE_MEM_WIDTH  = 32,
  parameter int MEM_DEPTH            = 1024,
  parameter int READ_LATENCY         = 2,
  parameter int WRITE_LATENCY        = 1
) (
  input  logic                              iClk,
  input  logic                              iReset,
  input  logic                              iReadRequest,
  input  logic                              iReadEnable,
  input  logic [INTERFACE_ADDR_WIDTH-1:0]   iReadAddress,
  output logic [D_WIDTH-1:0]                oReadData,
  output logic                              oReadDataValid,
  input  logic                              iWriteRequest,
  input  logic [INTERFACE_ADDR_WIDTH-1:0]   iWriteAddress,
  input  logic [INTERFACE_MEM_WIDTH/8-1:0]  iWriteEnable,
  input  logic [D_WIDTH-1:0]                iWriteData,
  output logic                              oWriteAccept,
  output logic                              oBusy
);

  localparam int MEM_BYTES = INTERFACE_MEM_WIDTH / 8;
  localparam int IDX_LSB   = CLogB2(MEM_BYTES);
  localparam int IDX_W     = CLogB2(MEM_DEPTH);
  localparam int MAX_LAT   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W     = (CLogB2(MAX_LAT) < 1) ? 1 : CLogB2(MAX_LAT);

  gm_state_e            rState, nState;
  logic [CNT_W-1:0]     rCnt, nCnt;
  logic                 rLastWasWrite, nLastWasWrite;

  logic [IDX_W-1:0]     rWrIdx;
  logic [D_WIDTH-1:0]   rWrData;
  logic [MEM_BYTES-1:0] rWrBe;

  logic                 readPending, writePending;
  logic                 takeRead, takeWrite;
  logic                 readDone, writeDone;

  logic [IDX_W-1:0]     rdIdx;
  logic [IDX_W-1:0]     ramAddr;
  logic                 ramEn, ramWe;
  logic [D_WIDTH-1:0]   ramRData;

  // Address bits outside the word index are deliberately ignored (wrap-around).
  logic                 unusedAddrBits;
  assign unusedAddrBits = ^{iReadAddress, iWriteAddress};

  assign readPending  = iReadRequest & iReadEnable;
  assign writePending = iWriteRequest;
  assign rdIdx        = iReadAddress[IDX_LSB +: IDX_W];

  // State, latency counter and fairness bit; reset aborts any transaction.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      rState        <= IDLE;
      rCnt          <= '0;
      rLastWasWrite <= 1'b1;
    end else begin
      rState        <= nState;
      rCnt          <= nCnt;
      rLastWasWrite <= nLastWasWrite;
    end
  end

  // Capture the write transaction at sampling so later input changes cannot disturb it.
  always_ff @(posedge iClk) begin
    if (takeWrite) begin
      rWrIdx  <= iWriteAddress[IDX_LSB +: IDX_W];
      rWrData <= iWriteData;
      rWrBe   <= iWriteEnable;
    end
  end

  // Next-state logic: arbitrate in IDLE, count down in READ/WRITE, flag the response cycle.
  always_comb begin
    nState        = rState;
    nCnt          = rCnt;
    nLastWasWrite = rLastWasWrite;
    takeRead      = 1'b0;
    takeWrite     = 1'b0;
    readDone      = 1'b0;
    writeDone     = 1'b0;
    case (rState)
      IDLE: begin
        // On contention serve whichever channel did not go last.
        if (readPending && (!writePending || rLastWasWrite)) begin
          takeRead      = 1'b1;
          nState        = READ;
          nCnt          = CNT_W'(READ_LATENCY - 1);
          nLastWasWrite = 1'b0;
        end else if (writePending) begin
          takeWrite     = 1'b1;
          nState        = WRITE;
          nCnt          = CNT_W'(WRITE_LATENCY - 1);
          nLastWasWrite = 1'b1;
        end
      end
      READ: begin
        if (rCnt != '0) begin
          nCnt = rCnt - 1'b1;
        end else begin
          readDone = 1'b1;
          nState   = IDLE;
        end
      end
      WRITE: begin
        if (rCnt != '0) begin
          nCnt = rCnt - 1'b1;
        end else begin
          writeDone = 1'b1;
          nState    = IDLE;
        end
      end
      default: nState = IDLE;
    endcase
  end

  // A reset in the response cycle suppresses the pulse and the commit.
  assign oReadDataValid = readDone & ~iReset;
  assign oWriteAccept   = writeDone & ~iReset;
  assign oReadData      = oReadDataValid ? ramRData : '0;
  assign oBusy          = (rState != IDLE);

  // The SRAM read is launched in the sample cycle and its output register
  // holds the word until the valid pulse; the write commits on the accept edge.
  assign ramWe   = oWriteAccept;
  assign ramEn   = takeRead | ramWe;
  assign ramAddr = (rState == WRITE) ? rWrIdx : rdIdx;

  gm_sram_be #(
    .WIDTH  (INTERFACE_MEM_WIDTH),
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (IDX_W)
  ) uSram (
    .iClk    (iClk),
    .iEn     (ramEn),
    .iWe     (ramWe),
    .iByteEn (rWrBe),
    .iAddr   (ramAddr),
    .iWData  (rWrData),
    .oRData  (ramRData)
  );

endmodule

// File: tb/tb_gm_responder.sv
// Directed scoreboard bench for gm_responder (default latencies plus a
// READ_LATENCY=4 instance for the reset-abort case).
module tb_gm_responder;

  localparam int RL  = 2;
  localparam int WL  = 1;
  localparam int RL4 = 4;

  logic        iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Instance with default latencies
  logic        rst, rdReq, rdEn, rdValid, wrReq, wrAccept, busy;
  logic [31:0] rdAddr, rdData, wrAddr, wrData;
  logic [3:0]  wrBe;

  // Instance with READ_LATENCY = 4
  logic        rst4, rd4Req, rd4En, rd4Valid, wr4Req, wr4Accept, busy4;
  logic [31:0] rd4Addr, rd4Data, wr4Addr, wr4Data;
  logic [3:0]  wr4Be;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb[$];

  gm_responder uDut (
    .iClk(iClk), .iReset(rst),
    .iReadRequest(rdReq), .iReadEnable(rdEn), .iReadAddress(rdAddr),
    .oReadData(rdData), .oReadDataValid(rdValid),
    .iWriteRequest(wrReq), .iWriteAddress(wrAddr), .iWriteEnable(wrBe),
    .iWriteData(wrData), .oWriteAccept(wrAccept), .oBusy(busy)
  );

  gm_responder #(.READ_LATENCY(RL4)) uDut4 (
    .iClk(iClk), .iReset(rst4),
    .iReadRequest(rd4Req), .iReadEnable(rd4En), .iReadAddress(rd4Addr),
    .oReadData(rd4Data), .oReadDataValid(rd4Valid),
    .iWriteRequest(wr4Req), .iWriteAddress(wr4Addr), .iWriteEnable(wr4Be),
    .iWriteData(wr4Data), .oWriteAccept(wr4Accept), .oBusy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a write in an IDLE cycle, wait for accept, check latency, release.
  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input string tag);
    int lat = 0;
    wrReq = 1'b1; wrAddr = addr; wrData = data; wrBe = be;
    while (lat < 20) begin
      @(negedge iClk);
      if (wrAccept) break;
      @(posedge iClk);
      lat++;
    end
    chk({tag, " acc_lat"}, 32'(lat), 32'(WL));
    chk({tag, " no_rdv"}, {31'd0, rdValid}, 32'd0);
    $display("write %s addr=%h data=%h be=%h lat=%0d", tag, addr, data, be, lat);
    wrReq = 1'b0;
    @(posedge iClk); #1;
  endtask

  // Issue a read in an IDLE cycle, expected word goes to the scoreboard and
  // is popped on the valid pulse. With hold set, the request stays up and the
  // address switches in the response cycle.
  task automatic doRead(input logic [31:0] addr, input logic [31:0] exp, input string tag,
                        input bit hold, input logic [31:0] nextAddr, output time tPulse);
    int lat = 0;
    logic [31:0] want;
    rdReq = 1'b1; rdEn = 1'b1; rdAddr = addr;
    sb.push_back(exp);
    while (lat < 20) begin
      @(negedge iClk);
      if (rdValid) break;
      if (lat == 1) chk({tag, " data_idle0"}, rdData, 32'd0);
      @(posedge iClk);
      lat++;
    end
    tPulse = $time;
    chk({tag, " rd_lat"}, 32'(lat), 32'(RL));
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    want = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
    chk({tag, " rdata"}, rdData, want);
    $display("read  %s addr=%h data=%h lat=%0d", tag, addr, rdData, lat);
    if (hold) rdAddr = nextAddr;
    else rdReq = 1'b0;
    @(posedge iClk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1, t2, tDummy;
    int  lat;

    rst = 1'b1; rdReq = 0; rdEn = 0; rdAddr = 0; wrReq = 0; wrAddr = 0; wrBe = 0; wrData = 0;
    rst4 = 1'b1; rd4Req = 0; rd4En = 0; rd4Addr = 0; wr4Req = 0; wr4Addr = 0; wr4Be = 0; wr4Data = 0;
    repeat (3) @(posedge iClk);
    #1; rst = 1'b0; rst4 = 1'b0;

    // Reset state
    @(negedge iClk);
    chk("rst valid", {31'd0, rdValid}, 32'd0);
    chk("rst accept", {31'd0, wrAccept}, 32'd0);
    chk("rst rdata", rdData, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    $display("reset released, outputs idle");
    @(posedge iClk); #1;

    // Write then read with default latencies
    doWrite(32'h10, 32'hDEADBEEF, 4'hF, "w10");
    doRead(32'h10, 32'hDEADBEEF, "r10", 1'b0, 32'h0, tDummy);

    // Byte-enable merge, then an all-zero enable that must leave memory alone
    doWrite(32'h20, 32'h11223344, 4'hF, "w20a");
    doWrite(32'h20, 32'hAABBCCDD, 4'b0101, "w20b");
    doRead(32'h20, 32'h11BB33DD, "r20", 1'b0, 32'h0, tDummy);
    doWrite(32'h20, 32'hFFFFFFFF, 4'h0, "w20z");
    doRead(32'h20, 32'h11BB33DD, "r20z", 1'b0, 32'h0, tDummy);

    // Address wrap-around and ignored byte-offset bits
    doWrite(32'h1000, 32'h00000001, 4'hF, "w1000");
    doRead(32'h0, 32'h00000001, "r0", 1'b0, 32'h0, tDummy);
    doRead(32'h13, 32'hDEADBEEF, "r13", 1'b0, 32'h0, tDummy);

    // Read request without the enable qualifier is never taken
    rdReq = 1'b1; rdEn = 1'b0; rdAddr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      chk("noen busy", {31'd0, busy}, 32'd0);
      chk("noen valid", {31'd0, rdValid}, 32'd0);
    end
    $display("read without enable ignored");
    @(posedge iClk); #1;
    rdReq = 1'b0;
    @(posedge iClk); #1;

    // Back-to-back reads, address switched in the response cycle
    doWrite(32'h40, 32'h40404040, 4'hF, "w40");
    doWrite(32'h44, 32'h44444444, 4'hF, "w44");
    doRead(32'h40, 32'h40404040, "r40", 1'b1, 32'h44, t1);
    doRead(32'h44, 32'h44444444, "r44", 1'b0, 32'h0, t2);
    chk("b2b spacing", 32'(t2 - t1), 32'd30);
    $display("back-to-back spacing=%0d", t2 - t1);

    // Simultaneous read and write held from reset release
    doWrite(32'h30, 32'h30303030, 4'hF, "w30");
    rst = 1'b1;
    rdReq = 1'b1; rdEn = 1'b1; rdAddr = 32'h30;
    wrReq = 1'b1; wrAddr = 32'h34; wrData = 32'hCAFEF00D; wrBe = 4'hF;
    sb.push_back(32'h30303030);
    sb.push_back(32'h30303030);
    @(posedge iClk); #1;
    rst = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge iClk);
      chk($sformatf("sim c%0d valid", c), {31'd0, rdValid}, {31'd0, (c == 2 || c == 7)});
      chk($sformatf("sim c%0d accept", c), {31'd0, wrAccept}, {31'd0, (c == 4 || c == 9)});
      if (rdValid) chk($sformatf("sim c%0d rdata", c), rdData, (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx);
      $display("sim cycle %0d valid=%0b accept=%0b data=%h", c, rdValid, wrAccept, rdData);
      if (c == 10) begin
        rdReq = 1'b0;
        wrReq = 1'b0;
      end
      @(posedge iClk);
    end
    #1;
    chk("sb empty", 32'(sb.size()), 32'd0);
    doRead(32'h34, 32'hCAFEF00D, "r34", 1'b0, 32'h0, tDummy);

    // READ_LATENCY=4 instance: preload, then reset two cycles into a read
    wr4Req = 1'b1; wr4Addr = 32'h50; wr4Data = 32'h5A5A1234; wr4Be = 4'hF;
    lat = 0;
    while (lat < 20) begin
      @(negedge iClk);
      if (wr4Accept) break;
      @(posedge iClk);
      lat++;
    end
    chk("l4 w acc_lat", 32'(lat), 32'(WL));
    $display("write l4 addr=00000050 lat=%0d", lat);
    wr4Req = 1'b0;
    @(posedge iClk); #1;

    rd4Req = 1'b1; rd4En = 1'b1; rd4Addr = 32'h50;
    @(posedge iClk);
    @(posedge iClk); #1;
    rst4 = 1'b1; rd4Req = 1'b0;
    @(negedge iClk);
    chk("l4 rst valid", {31'd0, rd4Valid}, 32'd0);
    @(posedge iClk); #1;
    rst4 = 1'b0;
    @(negedge iClk);
    chk("l4 rst busy", {31'd0, busy4}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("l4 no pulse", {31'd0, rd4Valid}, 32'd0);
      @(negedge iClk);
    end
    $display("reset mid-read aborted, busy=%0b", busy4);
    @(posedge iClk); #1;

    rd4Req = 1'b1; rd4En = 1'b1; rd4Addr = 32'h50;
    lat = 0;
    while (lat < 20) begin
      @(negedge iClk);
      if (rd4Valid) break;
      @(posedge iClk);
      lat++;
    end
    chk("l4 rd_lat", 32'(lat), 32'(RL4));
    chk("l4 rdata", rd4Data, 32'h5A5A1234);
    $display("read  l4 addr=00000050 data=%h lat=%0d", rd4Data, lat);
    rd4Req = 1'b0;
    @(posedge iClk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
